// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states, opcodes and response codes for the UART command parser
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    GET_CSUM = 3'd3,
    EXEC     = 3'd4,
    SEND     = 3'd5
  } state_e;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  // States in which the parser is willing to take a byte from the receiver.
  function automatic logic is_rx_state(input state_e s);
    return (s == IDLE) || (s == GET_ADDR) || (s == GET_DATA) || (s == GET_CSUM);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// rtl/uart_cmd_timeout.sv - inter-byte inactivity counter; restarts on clear, expires after TIMEOUT_CYCLES idle clocks
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // An arriving byte in the final cycle still wins over the timeout.
  assign expired = run && !clear && (count == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - UART byte-stream read/write command engine; optional trailing XOR checksum under UART_CMD_CHECKSUM_EN
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 8680
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] reg_wdata,
  output logic                  reg_we,
  input  logic [DATA_WIDTH-1:0] reg_rdata,
  output logic                  frame_err
);

  state_e state, state_next;
  logic   op_write;
  logic   rx_fire, tx_fire;
  logic   in_frame, expired;
  logic   opcode_ok;
`ifdef UART_CMD_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  assign rx_fire   = rx_valid && rx_ready;
  assign tx_fire   = tx_valid && tx_ready;
  assign in_frame  = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_CSUM);
  assign opcode_ok = (rx_data == DATA_WIDTH'(OP_WRITE)) || (rx_data == DATA_WIDTH'(OP_READ));

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (in_frame),
    .clear   (rx_fire),
    .expired (expired)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_fire) state_next = opcode_ok ? GET_ADDR : SEND;
      end
      GET_ADDR: begin
        if (rx_fire) begin
`ifdef UART_CMD_CHECKSUM_EN
          state_next = op_write ? GET_DATA : GET_CSUM;
`else
          state_next = op_write ? GET_DATA : EXEC;
`endif
        end else if (expired) begin
          state_next = IDLE;
        end
      end
      GET_DATA: begin
        if (rx_fire) begin
`ifdef UART_CMD_CHECKSUM_EN
          state_next = GET_CSUM;
`else
          state_next = EXEC;
`endif
        end else if (expired) begin
          state_next = IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      GET_CSUM: begin
        if (rx_fire)      state_next = (rx_data == csum) ? EXEC : SEND;
        else if (expired) state_next = IDLE;
      end
`endif
      EXEC:    state_next = SEND;
      SEND: begin
        if (tx_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // rx_ready is registered from the next state so it never follows rx_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      frame_err <= 1'b0;
      op_write  <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_next;
      rx_ready  <= is_rx_state(state_next);
      reg_we    <= (state_next == EXEC) && op_write;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_fire) begin
            op_write <= (rx_data == DATA_WIDTH'(OP_WRITE));
`ifdef UART_CMD_CHECKSUM_EN
            csum     <= rx_data;
`endif
            if (!opcode_ok) begin
              tx_data   <= DATA_WIDTH'(RSP_ERR);
              tx_valid  <= 1'b1;
              frame_err <= 1'b1;
            end
          end
        end
        GET_ADDR, GET_DATA: begin
          if (rx_fire) begin
            if (state == GET_ADDR) reg_addr  <= rx_data[ADDR_WIDTH-1:0];
            else                   reg_wdata <= rx_data;
`ifdef UART_CMD_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
          end else if (expired) begin
            frame_err <= 1'b1;
          end
        end
`ifdef UART_CMD_CHECKSUM_EN
        GET_CSUM: begin
          if (rx_fire) begin
            if (rx_data != csum) begin
              tx_data   <= DATA_WIDTH'(RSP_ERR);
              tx_valid  <= 1'b1;
              frame_err <= 1'b1;
            end
          end else if (expired) begin
            frame_err <= 1'b1;
          end
        end
`endif
        EXEC: begin
          tx_data  <= op_write ? DATA_WIDTH'(RSP_ACK) : reg_rdata;
          tx_valid <= 1'b1;
        end
        SEND: begin
          if (tx_fire) tx_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - self-checking bench for uart_cmd_parser against a frame-level model
module tb_uart_cmd_parser;

  localparam int TO = 100;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       frame_err;

  uart_cmd_parser #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  bus_mem   [256];
  logic [7:0]  model_mem [256];
  assign reg_rdata = bus_mem[reg_addr];
  always @(posedge clk) if (reg_we) bus_mem[reg_addr] <= reg_wdata;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_we[$];
  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, rise_cyc = 0;
  int err_exp = 0, err_seen = 0, we_seen = 0, unexp_tx = 0, unexp_we = 0;
  logic [7:0]  last_tx = 8'h00, prev_data = 8'h00;
  logic [15:0] last_we = 16'h0000;
  logic        prev_hold = 1'b0, prev_valid = 1'b0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Frame-level model: what the link must answer and write for one frame.
  function automatic void model_frame(input bq_t f, input bit timed_out);
    logic [7:0] x;
    if (timed_out) begin
      err_exp++;
      return;
    end
    if (f[0] != 8'h57 && f[0] != 8'h52) begin
      exp_tx.push_back(8'h45);
      err_exp++;
      return;
    end
`ifdef UART_CMD_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
    if (x != f[f.size()-1]) begin
      exp_tx.push_back(8'h45);
      err_exp++;
      return;
    end
`else
    x = 8'h00;
`endif
    if (f[0] == 8'h57) begin
      exp_we.push_back({f[1], f[2]});
      model_mem[f[1]] = f[2];
      exp_tx.push_back(8'h4B ^ x ^ x);
    end else begin
      exp_tx.push_back(model_mem[f[1]]);
    end
  endfunction

  function automatic bq_t cs(input bq_t f);
    bq_t r;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] x;
`endif
    r = f;
`ifdef UART_CMD_CHECKSUM_EN
    x = 8'h00;
    foreach (f[i]) x ^= f[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) check("rx_accept", rx_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input bq_t f, input int gap_last);
    for (int i = 0; i < f.size(); i++) begin
      if (i == f.size() - 1 && gap_last > 0) begin
        repeat (gap_last) @(posedge clk);
        #1;
      end
      send_byte(f[i]);
    end
  endtask

  task automatic send_frame(input bq_t f, input int gap_last);
    model_frame(f, 1'b0);
    send_bytes(f, gap_last);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || tx_valid) && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("drain_tx_queue", exp_tx.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hold) begin
        check("tx_hold_valid", tx_valid, 1);
        check("tx_hold_data", tx_data, prev_data);
      end
      if (tx_valid) check("rx_ready_in_send", rx_ready, 0);
      if (tx_valid && !prev_valid) rise_cyc = cyc;
      if (tx_valid && tx_ready) begin
        last_tx = tx_data;
        if (exp_tx.size() == 0) unexp_tx++;
        else check("tx_data", tx_data, exp_tx.pop_front());
      end
      if (reg_we) begin
        we_seen++;
        last_we = {reg_addr, reg_wdata};
        if (exp_we.size() == 0) unexp_we++;
        else check("reg_write", {reg_addr, reg_wdata}, exp_we.pop_front());
      end
      if (frame_err) err_seen++;
      prev_hold  = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_valid = tx_valid;
    end
  end

  initial begin
    bq_t f;
    int e0, w0;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i]   = 8'(i) ^ 8'h2C;
      model_mem[i] = 8'(i) ^ 8'h2C;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_reg_wdata", reg_wdata, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // read of 0x10 returns the bus value, two cycles after the last byte
    w0 = we_seen;
    f = {8'h52, 8'h10};
    send_frame(cs(f), 0);
    wait_idle();
    check("read_latency", rise_cyc - acc_cyc, 2);
    check("read_literal", last_tx, 8'h3C);
    check("read_no_we", we_seen - w0, 0);

    f = {8'h57, 8'h10, 8'hA5};
    send_frame(cs(f), 0);
    wait_idle();
    check("write_latency", rise_cyc - acc_cyc, 2);
    check("write_literal", last_we, 16'h10A5);
    check("ack_literal", last_tx, 8'h4B);

    e0 = err_seen;
    f = {8'h41};
    send_frame(f, 0);
    wait_idle();
    check("badop_err_pulse", err_seen - e0, 1);
    check("badop_literal", last_tx, 8'h45);
    f = {8'h57, 8'h01, 8'h02};
    send_frame(cs(f), 0);
    wait_idle();

    // partial frame then silence: error pulse, no response
    e0 = err_seen;
    f = {8'h57, 8'h10};
    model_frame(f, 1'b1);
    send_bytes(f, 0);
    repeat (TO + 5) @(posedge clk);
    #1;
    check("timeout_err_pulse", err_seen - e0, 1);
    f = {8'h52, 8'h20};
    send_frame(cs(f), 0);
    wait_idle();
    check("post_timeout_read", last_tx, 8'h0C);

    e0 = err_seen;
    f = {8'h52, 8'h30};
    send_frame(cs(f), TO - 1);
    wait_idle();
    check("gap_edge_no_err", err_seen - e0, 0);

    // response back-pressured while the next opcode waits
    tx_ready = 1'b0;
    f = {8'h52, 8'h40};
    send_frame(cs(f), 0);
    rx_data  = 8'h57;
    rx_valid = 1'b1;
    repeat (50) @(negedge clk);
    check("pending_not_taken", rx_ready, 0);
    check("held_response", tx_data, 8'h6C);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    f = {8'h57, 8'h41, 8'h99};
    send_frame(cs(f), 0);
    wait_idle();

    // reset in the middle of a write drops it
    f = {8'h57, 8'h50};
    send_bytes(f, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_rx_ready", rx_ready, 0);
    check("midrst_reg_addr", reg_addr, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    f = {8'h52, 8'h50};
    send_frame(cs(f), 0);
    wait_idle();
    check("midrst_no_write", last_tx, 8'h7C);

`ifdef UART_CMD_CHECKSUM_EN
    f = {8'h57, 8'h10, 8'hA5, 8'hE2};
    send_frame(f, 0);
    wait_idle();
    check("csum_ok_ack", last_tx, 8'h4B);
    e0 = err_seen;
    w0 = we_seen;
    f = {8'h57, 8'h10, 8'hA5, 8'h00};
    send_frame(f, 0);
    wait_idle();
    check("csum_bad_rsp", last_tx, 8'h45);
    check("csum_bad_no_we", we_seen - w0, 0);
    check("csum_bad_err", err_seen - e0, 1);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("frame_err_total", err_seen, err_exp);
    check("writes_pending", exp_we.size(), 0);
    check("unexpected_tx", unexp_tx, 0);
    check("unexpected_we", unexp_we, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

endmodule
